chunked_addsub: RTL and testbench

Parametrised, multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair CHUNK bits per clock through one shared CHUNK-bit ripple stage. It is the sequential, handshaked successor to the team's 4-bit combinational ripple adder. Wide arithmetic is traded for area and a short critical path. It sits between an operand source and a result sink, both speaking valid/ready.

---
 rtl/chunked_addsub_pkg.sv | 13 +
 rtl/chunked_addsub_chunk_adder.sv | 26 ++
 rtl/chunked_addsub.sv | 105 ++++++++++
 tb/tb_chunked_addsub.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/chunked_addsub_pkg.sv
// Shared types for the chunked adder/subtractor: FSM states and op-select encoding.
package chunked_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; c_msb exposes the carry into the top bit
// so the caller can form signed overflow on the final chunk.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/subtract through one shared CHUNK-bit ripple stage,
// with valid/ready on both operand and result sides.
module chunked_addsub
    import chunked_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             carryin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t            state, state_n;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  xq, yq;
    logic              subq, carry;
    logic [CHUNK-1:0]  a, b, s_chunk;
    logic              c_out, c_msb;
    logic [WIDTH-1:0]  s_next;
    logic              accept, last;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (idx == LAST);

    // Per-chunk operand mux; subtraction feeds the inverted Y slice.
    always_comb begin
        a      = xq[int'(idx)*CHUNK +: CHUNK];
        b      = yq[int'(idx)*CHUNK +: CHUNK] ^ {CHUNK{subq == OP_SUB}};
        s_next = S;
        s_next[int'(idx)*CHUNK +: CHUNK] = s_chunk;
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a),
        .b     (b),
        .cin   (carry),
        .s     (s_chunk),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept)    state_n = RUN;
            RUN:     if (last)      state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            xq       <= '0;
            yq       <= '0;
            subq     <= OP_ADD;
            carry    <= 1'b0;
            S        <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            xq    <= X;
            yq    <= Y;
            subq  <= sub;
            carry <= carryin;
            idx   <= '0;
            S     <= '0;
        end else if (state == RUN) begin
            S     <= s_next;
            carry <= c_out;
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
                carryout <= c_out;
                overflow <= c_msb ^ c_out;
                zero     <= (s_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed bench for chunked_addsub: 16/4 instance for most scenarios, 16/16 for the single-chunk case.
module tb_chunked_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, carryin, sub, out_valid, out_ready;
    logic [15:0] X, Y, S;
    logic        carryout, overflow, zero;

    logic        w_in_valid, w_in_ready, w_carryin, w_sub, w_out_valid, w_out_ready;
    logic [15:0] w_X, w_Y, w_S;
    logic        w_carryout, w_overflow, w_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .carryin(carryin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .carryout(carryout), .overflow(overflow), .zero(zero)
    );

    chunked_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .X(w_X), .Y(w_Y), .carryin(w_carryin), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .S(w_S), .carryout(w_carryout), .overflow(w_overflow), .zero(w_zero)
    );

    // Drives one operation with out_ready high; scrambles operands after the
    // accepting edge. Called at posedge+1.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sb,
                          output logic [15:0] rs, output logic rco,
                          output logic rov, output logic rz, output int lat);
        int guard = 0;
        X = x; Y = y; carryin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        in_valid = 1'b0; X = 16'hDEAD; Y = 16'hBEEF; carryin = ~ci; sub = ~sb;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rs = S; rco = carryout; rov = overflow; rz = zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({S, carryout, overflow, zero} !== 19'd0)
            begin errors++; $display("FAIL reset_outputs got S=%h co=%b ov=%b z=%b exp all 0", S, carryout, overflow, zero); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_add;
        logic [15:0] rs; logic rco, rov, rz; int lat;
        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, rs, rco, rov, rz, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL zero_latency got %0d exp 4", lat); end
        checks++; if ({rs, rco, rov, rz} !== {16'h0000, 3'b001})
            begin errors++; $display("FAIL add_zero got S=%h co=%b ov=%b z=%b exp 0000 0 0 1", rs, rco, rov, rz); end
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, rs, rco, rov, rz, lat);
        checks++; if ({rs, rco, rov, rz} !== {16'hFFFF, 3'b100})
            begin errors++; $display("FAIL add_ones got S=%h co=%b ov=%b z=%b exp ffff 1 0 0", rs, rco, rov, rz); end
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rco, rov, rz, lat);
        checks++; if ({rs, rco, rov, rz} !== {16'h8000, 3'b010})
            begin errors++; $display("FAIL add_overflow got S=%h co=%b ov=%b z=%b exp 8000 0 1 0", rs, rco, rov, rz); end
    endtask

    task automatic test_sub;
        logic [15:0] rs; logic rco, rov, rz; int lat;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rco, rov, rz, lat);
        checks++; if ({rs, rco, rov, rz} !== {16'hFFFE, 3'b000})
            begin errors++; $display("FAIL sub_borrow got S=%h co=%b ov=%b z=%b exp fffe 0 0 0", rs, rco, rov, rz); end
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, rs, rco, rov, rz, lat);
        checks++; if ({rs, rco, rov, rz} !== {16'h0002, 3'b100})
            begin errors++; $display("FAIL sub_pos got S=%h co=%b ov=%b z=%b exp 0002 1 0 0", rs, rco, rov, rz); end
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, rs, rco, rov, rz, lat);
        checks++; if ({rs, rco} !== {16'h0001, 1'b1})
            begin errors++; $display("FAIL sub_chain got S=%h co=%b exp 0001 1", rs, rco); end
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, rs, rco, rov, rz, lat);
        checks++; if ({rs, rco, rov} !== {16'h7FFF, 2'b11})
            begin errors++; $display("FAIL sub_overflow got S=%h co=%b ov=%b exp 7fff 1 1", rs, rco, rov); end
    endtask

    task automatic test_backpressure;
        int lat = 0;
        out_ready = 1'b0; X = 16'h1234; Y = 16'h4321; carryin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        X = 16'h0100; Y = 16'h0200; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({out_valid, in_ready, S} !== {2'b10, 16'h5555})
                begin errors++; $display("FAIL bp_hold%0d got ov=%b ir=%b S=%h exp 1 0 5555", i, out_valid, in_ready, S); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid} !== 2'b10)
            begin errors++; $display("FAIL bp_release got ir=%b ov=%b exp 1 0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept_next got ir=%b exp 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if ({lat, S} !== {32'd4, 16'h0300})
            begin errors++; $display("FAIL bp_next_result got lat=%0d S=%h exp 4 0300", lat, S); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [15:0] rs; logic rco, rov, rz; int lat;
        X = 16'hAAAA; Y = 16'h1111; carryin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (S[7:0] !== 8'hBB) begin errors++; $display("FAIL partial_s got %h exp bb", S[7:0]); end
        rst = 1'b1; #1;
        checks++; if ({out_valid, in_ready, S} !== 18'd0)
            begin errors++; $display("FAIL mid_reset got ov=%b ir=%b S=%h exp 0 0 0000", out_valid, in_ready, S); end
        @(posedge clk); #1 rst = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_release got ir=%b exp 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL aborted_no_result%0d got ov=%b exp 0", i, out_valid); end
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, rs, rco, rov, rz, lat);
        checks++; if ({lat, rs} !== {32'd4, 16'h0100})
            begin errors++; $display("FAIL after_reset_op got lat=%0d S=%h exp 4 0100", lat, rs); end
    endtask

    task automatic test_back_to_back;
        int first = -1, second = -1, guard = 0;
        logic acc;
        X = 16'h0001; Y = 16'h0002; carryin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 0; e < 10; e++) begin
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) begin
                if (first < 0) first = e;
                else if (second < 0) second = e;
            end
        end
        in_valid = 1'b0;
        checks++; if (second - first !== 6)
            begin errors++; $display("FAIL throughput got %0d exp 6 (first=%0d second=%0d)", second - first, first, second); end
        while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    endtask

    task automatic test_wide;
        int lat = 0;
        w_X = 16'hFFFF; w_Y = 16'h0001; w_carryin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0; w_X = 16'h1234;
        while (!w_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 1) begin errors++; $display("FAIL wide_latency got %0d exp 1", lat); end
        checks++; if ({w_S, w_carryout, w_overflow, w_zero} !== {16'h0000, 3'b101})
            begin errors++; $display("FAIL wide_result got S=%h co=%b ov=%b z=%b exp 0000 1 0 1", w_S, w_carryout, w_overflow, w_zero); end
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid = 0; X = 0; Y = 0; carryin = 0; sub = 0; out_ready = 0;
        w_in_valid = 0; w_X = 0; w_Y = 0; w_carryin = 0; w_sub = 0; w_out_ready = 0;
        test_reset;
        test_add;
        test_sub;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        test_wide;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
